elliot_activation_param: RTL

Parametrised, multi-cycle Elliott activation unit for the neural-network datapath. Computes y = x / (1 + |x|) (bipolar) or y = 0.5·x/(1 + |x|) + 0.5 (unipolar) on signed fixed-point operands using an iterative restoring divider. Operates under a start/end_signal handshake and replaces the fixed-width activation in neuron output stages. Width, fraction bits and output mode are selectable.

---
 rtl/elliot_activation_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/elliot_activation_param.sv
// elliot_activation_param
//   Multi-cycle Elliott activation on signed fixed-point operands.
//     mode = 0 (bipolar)  : y = x / (1 + |x|)
//     mode = 1 (unipolar) : y = 0.5 * x / (1 + |x|) + 0.5
//   The quotient |x| / (ONE + |x|) is produced by a restoring divider that
//   retires one fraction bit per cycle, so latency is FRAC+1 cycles.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   x           signed operand, sampled when start is accepted
//   start       request, accepted only while idle
//   mode        0 = bipolar, 1 = unipolar, sampled with x
//   y           registered result, held until the next completion
//   end_signal  one-cycle pulse marking y valid
//   busy        high while an operation is in flight
module elliot_activation_param #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             start,
  input  logic             mode,
  output logic [WIDTH-1:0] y,
  output logic             end_signal,
  output logic             busy
);

  localparam int             CW       = $clog2(FRAC + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FRAC - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic             sgn_q;
  logic             mode_q;
  logic [WIDTH:0]   den_q;
  logic [WIDTH:0]   rem_q;
  logic [FRAC-1:0]  q_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] y_q;
  logic             end_q;
  logic             busy_q;

  logic [WIDTH-1:0] mag_d;
  logic [WIDTH:0]   den_d;
  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH:0]   rem_step_d;
  logic             qbit_d;
  logic [FRAC:0]    q_shift_d;
  logic [FRAC-1:0]  q_step_d;
  logic [WIDTH-1:0] q_ext_d;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] uni_sum_d;
  logic [WIDTH-1:0] y_fin_d;

  // Operand load values, one restoring-divider step and the final scaling.
  always_comb begin
    mag_d       = '0;
    den_d       = '0;
    rem_shift_d = '0;
    rem_step_d  = '0;
    qbit_d      = 1'b0;
    q_shift_d   = '0;
    q_step_d    = '0;
    q_ext_d     = '0;
    s_d         = '0;
    uni_sum_d   = '0;
    y_fin_d     = '0;

    // Negating the most negative value yields 2^(WIDTH-1), which is exact
    // when read as unsigned.
    if (x[WIDTH-1]) begin
      mag_d = -x;
    end else begin
      mag_d = x;
    end
    den_d = {1'b0, ONE} + {1'b0, mag_d};

    // rem < den < 2^WIDTH always, so the top bit of rem is zero and the
    // shifted value still fits in WIDTH+1 bits.
    rem_shift_d = {rem_q[WIDTH-1:0], 1'b0};
    if (rem_shift_d >= den_q) begin
      rem_step_d = rem_shift_d - den_q;
      qbit_d     = 1'b1;
    end else begin
      rem_step_d = rem_shift_d;
      qbit_d     = 1'b0;
    end
    q_shift_d = {q_q, qbit_d};
    q_step_d  = q_shift_d[FRAC-1:0];

    q_ext_d = {{(WIDTH-FRAC){1'b0}}, q_q};
    if (sgn_q) begin
      s_d = -q_ext_d;
    end else begin
      s_d = q_ext_d;
    end
    // ONE + s lies in (0, 2*ONE), so the arithmetic shift never sees a
    // negative value and simply truncates.
    uni_sum_d = ONE + s_d;
    if (mode_q) begin
      y_fin_d = {uni_sum_d[WIDTH-1], uni_sum_d[WIDTH-1:1]};
    end else begin
      y_fin_d = s_d;
    end
  end

  // Control FSM with divider state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      mode_q  <= 1'b0;
      den_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          end_q <= 1'b0;
          if (start) begin
            sgn_q   <= x[WIDTH-1];
            mode_q  <= mode;
            den_q   <= den_d;
            rem_q   <= {1'b0, mag_d};
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_DIV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_DIV: begin
          end_q <= 1'b0;
          rem_q <= rem_step_d;
          q_q   <= q_step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIN;
          end else begin
            state_q <= S_DIV;
          end
        end
        S_FIN: begin
          y_q     <= y_fin_d;
          end_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          end_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign y          = y_q;
  assign end_signal = end_q;
  assign busy       = busy_q;

endmodule
